// File: rtl/ntt_stage_ctrl_if.sv
// Coefficient RAM / twiddle ROM / butterfly bus of the NTT sequencer.
// master = sequencer side, slave = memory and butterfly side.
interface ntt_stage_ctrl_if #(
  parameter int LOGN = 4
);
  logic            rd_en;
  logic [LOGN-1:0] rd_addr_x;
  logic [LOGN-1:0] rd_addr_y;
  logic [LOGN-2:0] tw_addr;
  logic            bf_en;
  logic            bf_valid;
  logic            wr_en;
  logic [LOGN-1:0] wr_addr_x;
  logic [LOGN-1:0] wr_addr_y;

  modport master (
    output rd_en,
    output rd_addr_x,
    output rd_addr_y,
    output tw_addr,
    output bf_en,
    input  bf_valid,
    output wr_en,
    output wr_addr_x,
    output wr_addr_y
  );

  modport slave (
    input  rd_en,
    input  rd_addr_x,
    input  rd_addr_y,
    input  tw_addr,
    input  bf_en,
    output bf_valid,
    input  wr_en,
    input  wr_addr_x,
    input  wr_addr_y
  );
endinterface

// File: rtl/ntt_stage_ctrl.sv
// In-place radix-2 DIF NTT sequencer: issue, drain, write-back per stage.
// Optional NTT_CTRL_HOLD_EN adds a hold input that stalls issue in RUN.
module ntt_stage_ctrl #(
  parameter int LOGN   = 4,
  parameter int BF_LAT = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
`ifdef NTT_CTRL_HOLD_EN
  input  logic            hold,
`endif
  output logic            busy,
  output logic            done,
  output logic [LOGN-1:0] stage,
  output logic            align_err,
  ntt_stage_ctrl_if.master bus
);

  localparam int KW = LOGN - 1;
  localparam int DL = BF_LAT + 1;
  localparam logic [LOGN-1:0] ONE  = LOGN'(1);
  localparam logic [LOGN-1:0] LM1  = LOGN'(LOGN - 1);
  localparam logic [KW-1:0]   KMAX = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_FIN
  } state_t;

  typedef struct packed {
    logic            tag;
    logic [LOGN-1:0] ax;
    logic [LOGN-1:0] ay;
  } slot_t;

  state_t          st_q, st_d;
  logic [KW-1:0]   k_q, k_d;
  logic [LOGN-1:0] stg_q, stg_d;
  slot_t           dl_q [DL];
  logic            bf_en_q;
  logic            align_q;
  logic            hold_i;
  logic            issue;
  logic            pend;

  logic [LOGN-1:0] kx, bpos, lmask;
  logic [LOGN-1:0] ax, ay;
  logic [KW-1:0]   tw;

`ifdef NTT_CTRL_HOLD_EN
  assign hold_i = hold;
`else
  assign hold_i = 1'b0;
`endif

  // Insert a 0/1 at bit b = LOGN-1-stage to split k into the x/y pair.
  always_comb begin
    kx    = {1'b0, k_q};
    bpos  = LM1 - stg_q;
    lmask = (ONE << bpos) - ONE;
    ax    = ((kx & ~lmask) << 1) | (kx & lmask);
    ay    = ax | (ONE << bpos);
    tw    = (k_q & lmask[KW-1:0]) << stg_q;
  end

  // Writes still in flight, excluding the slot at the output.
  always_comb begin
    pend = 1'b0;
    for (int i = 0; i < DL - 1; i++) begin
      pend = pend | dl_q[i].tag;
    end
  end

  always_comb begin
    st_d  = st_q;
    k_d   = k_q;
    stg_d = stg_q;
    issue = 1'b0;
    unique case (st_q)
      S_IDLE: begin
        if (start) begin
          st_d  = S_RUN;
          stg_d = '0;
          k_d   = '0;
        end
      end
      S_RUN: begin
        if (!hold_i) begin
          issue = 1'b1;
          if (k_q == KMAX) begin
            st_d = S_DRAIN;
            k_d  = '0;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (!pend) begin
          if (stg_q == LM1) begin
            st_d = S_FIN;
          end else begin
            st_d  = S_RUN;
            stg_d = stg_q + 1'b1;
          end
        end
      end
      S_FIN: begin
        st_d = S_IDLE;
      end
      default: begin
        st_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q    <= S_IDLE;
      k_q     <= '0;
      stg_q   <= '0;
      bf_en_q <= 1'b0;
      align_q <= 1'b0;
      for (int i = 0; i < DL; i++) begin
        dl_q[i] <= '0;
      end
    end else begin
      st_q    <= st_d;
      k_q     <= k_d;
      stg_q   <= stg_d;
      bf_en_q <= issue;
      align_q <= align_q |
                 (bus.bf_valid != dl_q[DL-1].tag);
      dl_q[0].tag <= issue;
      dl_q[0].ax  <= issue ? ax : '0;
      dl_q[0].ay  <= issue ? ay : '0;
      for (int i = 1; i < DL; i++) begin
        dl_q[i] <= dl_q[i-1];
      end
    end
  end

  assign bus.rd_en     = issue;
  assign bus.rd_addr_x = issue ? ax : '0;
  assign bus.rd_addr_y = issue ? ay : '0;
  assign bus.tw_addr   = issue ? tw : '0;
  assign bus.bf_en     = bf_en_q;
  assign bus.wr_en     = dl_q[DL-1].tag;
  assign bus.wr_addr_x = dl_q[DL-1].ax;
  assign bus.wr_addr_y = dl_q[DL-1].ay;

  assign busy      = (st_q != S_IDLE);
  assign done      = (st_q == S_FIN);
  assign stage     = stg_q;
  assign align_err = align_q;

endmodule

// File: tb/tb_ntt_stage_ctrl.sv
// Bench for ntt_stage_ctrl: cycle-exact schedule from a pair/twiddle model.
// Hold scenario is compiled in only with NTT_CTRL_HOLD_EN.
module tb_ntt_stage_ctrl;

  localparam int LOGN   = 4;
  localparam int BF_LAT = 4;
  localparam int N      = 1 << LOGN;
  localparam int H      = N / 2;
  localparam int NC     = 128;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
`ifdef NTT_CTRL_HOLD_EN
  logic            hold;
`endif
  logic            busy;
  logic            done;
  logic            align_err;
  logic [LOGN-1:0] stage;

  ntt_stage_ctrl_if #(.LOGN(LOGN)) bus ();

  int         lat = 4;
  logic [7:0] en_hist;

  always #5 clk = ~clk;

  // Model butterfly: valid is en delayed by lat cycles.
  always @(posedge clk or posedge reset) begin
    if (reset) en_hist <= '0;
    else       en_hist <= {en_hist[6:0], bus.bf_en};
  end
  assign bus.bf_valid = en_hist[lat-1];

  ntt_stage_ctrl #(
    .LOGN   (LOGN),
    .BF_LAT (BF_LAT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
`ifdef NTT_CTRL_HOLD_EN
    .hold      (hold),
`endif
    .busy      (busy),
    .done      (done),
    .stage     (stage),
    .align_err (align_err),
    .bus       (bus)
  );

  int n_asrt = 0;
  int n_fail = 0;

  int e_rd  [NC];
  int e_ax  [NC];
  int e_ay  [NC];
  int e_tw  [NC];
  int e_stg [NC];
  int done_c;

  function automatic int rd_at(input int i);
    return (i >= 0 && i < NC) ? e_rd[i] : 0;
  endfunction

  function automatic int ax_at(input int i);
    return (i >= 0 && i < NC) ? e_ax[i] : 0;
  endfunction

  function automatic int ay_at(input int i);
    return (i >= 0 && i < NC) ? e_ay[i] : 0;
  endfunction

  task automatic set_hold(input bit v);
`ifdef NTT_CTRL_HOLD_EN
    hold = v;
`else
    if (v) $display("note: hold requested without hold port");
`endif
  endtask

  task automatic chk(input string tag, input int c,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cyc %0d: observed %0h expected %0h",
             tag, c, obs, exp);
    end
  endtask

  // Schedule from the DIF definition: in stage s, pairs are half apart
  // inside blocks of 2*half; twiddle exponent is (j mod half) * 2^s.
  task automatic build(input int hl);
    int t, half, st0, lastw;
    for (int i = 0; i < NC; i++) begin
      e_rd[i] = 0; e_ax[i] = 0; e_ay[i] = 0;
      e_tw[i] = 0; e_stg[i] = 0;
    end
    t = 1;
    for (int s = 0; s < LOGN; s++) begin
      half = N >> (s + 1);
      st0  = t;
      for (int j = 0; j < H; j++) begin
        if (s == 0 && j == 2) t += hl;
        e_rd[t] = 1;
        e_ax[t] = (j / half) * 2 * half + (j % half);
        e_ay[t] = e_ax[t] + half;
        e_tw[t] = ((j % half) << s) % H;
        t++;
      end
      lastw = t - 1 + BF_LAT + 1;
      for (int c = st0; c <= lastw; c++) e_stg[c] = s;
      t = lastw + 1;
    end
    done_c = t;
    e_stg[done_c] = LOGN - 1;
  endtask

  task automatic check_idle(input string tag, input int c);
    chk(tag, c,
        {3'b0, busy, done, align_err, stage,
         bus.rd_en, bus.bf_en, bus.wr_en,
         bus.rd_addr_x, bus.rd_addr_y, bus.tw_addr,
         bus.wr_addr_x, bus.wr_addr_y},
        32'd0);
  endtask

  task automatic run(input int l, input int hl,
                     input int rst_at, input bit rnd);
    bit acc;
    lat = l;
    build(hl);
    @(negedge clk);
    reset = 1'b1;
    start = 1'b1;
    set_hold(1'b0);
    @(negedge clk);
    check_idle("in_reset", 0);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_idle("post_reset", 0);
    repeat ($urandom_range(0, 4)) @(negedge clk);
    start = 1'b1;
    acc = 1'b0;
    for (int c = 1; c < 72; c++) begin
      @(posedge clk);
      if (c == rst_at) begin
        #1 reset = 1'b1;
      end
      @(negedge clk);
      if (rst_at > 0 && c >= rst_at) begin
        check_idle("abort", c);
      end else begin
        chk("rd_en", c, bus.rd_en, e_rd[c]);
        chk("rd_x", c, bus.rd_addr_x, e_ax[c]);
        chk("rd_y", c, bus.rd_addr_y, e_ay[c]);
        chk("tw", c, bus.tw_addr, e_tw[c]);
        chk("bf_en", c, bus.bf_en, rd_at(c - 1));
        chk("wr_en", c, bus.wr_en, rd_at(c - 1 - BF_LAT));
        chk("wr_x", c, bus.wr_addr_x, ax_at(c - 1 - BF_LAT));
        chk("wr_y", c, bus.wr_addr_y, ay_at(c - 1 - BF_LAT));
        chk("busy", c, busy, c <= done_c);
        chk("done", c, done, c == done_c);
        if (c <= done_c) chk("stage", c, stage, e_stg[c]);
        chk("align", c, align_err, acc);
      end
      if (rd_at(c - 1 - l) != rd_at(c - 1 - BF_LAT)) acc = 1'b1;
      if (rst_at > 0 && c == rst_at + 1) reset = 1'b0;
      if (rst_at > 0 && c >= rst_at - 1) start = 1'b0;
      else if (c < done_c) start = rnd ? 1'($urandom % 2) : 1'b1;
      else start = (c == done_c);
      set_hold(c + 1 >= 3 && c + 1 <= 2 + hl);
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    set_hold(1'b0);
    run(4, 0, 0, 1'b0);
    run(3, 0, 20, 1'b1);
    run(4, 0, 0, 1'b1);
`ifdef NTT_CTRL_HOLD_EN
    run(4, 3, 0, 1'b0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asrt, n_fail);
    $finish;
  end

endmodule

// File: doc/ntt_stage_ctrl.md
Name: ntt_stage_ctrl

Overview:
- Sequencer for one in-place radix-2 DIF NTT of N = 2^LOGN points.
- Drives an external synchronous-read coefficient RAM, a twiddle ROM of N/2 entries (entry i = w^i mod p), and the existing ntt2_pipeline butterfly (en/valid).
- Issues one butterfly per cycle per stage, drains the pipeline between stages to avoid RAW hazards, and pulses done after the last stage's final write.

Parameters:
- LOGN, 4, log2 of transform size; N = 2^LOGN, N/2 butterflies per stage, LOGN stages.
- BF_LAT, 4, butterfly latency in cycles: en to valid.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begin a transform; sampled only in IDLE.
- busy  out  1  high in RUN, DRAIN and DONE.
- done  out  1  one-cycle pulse in DONE.
- stage  out  LOGN  current stage index, 0..LOGN-1.
- rd_en  out  1  RAM read strobe for the x/y pair.
- rd_addr_x  out  LOGN  x operand address.
- rd_addr_y  out  LOGN  y operand address.
- tw_addr  out  LOGN-1  twiddle ROM address, read in the same cycle as rd_en.
- bf_en  out  1  to butterfly en; rd_en delayed 1 cycle (RAM read latency).
- bf_valid  in  1  from butterfly valid.
- wr_en  out  1  RAM write strobe for the xout/yout pair.
- wr_addr_x  out  LOGN  x result address.
- wr_addr_y  out  LOGN  y result address.
- align_err  out  1  sticky: bf_valid disagreed with the expected write slot.

Behaviour:
- Reset: state IDLE; stage, counters, delay line, every output = 0. Takes effect immediately.
- Reset mid-operation aborts the transform: no further wr_en, no done.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: start=1 -> RUN, stage=0, k=0. Otherwise stay.
- RUN: rd_en=1 each cycle and k increments. After issue with k=N/2-1 -> DRAIN, k=0.
- DRAIN: no issue. Leave the cycle after the stage's last wr_en, i.e. when the delay line is empty:
  - stage<LOGN-1 -> RUN, stage+1;
  - else -> DONE.
- DONE: done=1 for one cycle -> IDLE.
- start outside IDLE is ignored, including in DONE.
- Address generation, butterfly counter k (LOGN-1 bits), bit position b = LOGN-1-stage:
  - rd_addr_x = k with a 0 inserted at bit b;
  - rd_addr_y = k with a 1 inserted at bit b;
  - tw_addr = (k mod 2^b) << stage, truncated to LOGN-1 bits.
- Write path: shift register of depth 1+BF_LAT carrying {tag, addr_x, addr_y}, where tag = rd_en. It advances every cycle.
  - wr_en = output tag; wr_addr_x/wr_addr_y = output addresses.
  - First write occurs 1+BF_LAT cycles after the matching rd_en.
- align_err sets whenever bf_valid differs from the output tag. Cleared only by reset.
- Timing (no stalls):
  - stage period = N/2 + BF_LAT + 1 cycles;
  - start sampled in cycle 0 -> first rd_en in cycle 1;
  - last wr_en in cycle LOGN*(N/2+BF_LAT+1);
  - done in the following cycle.
  - Defaults: first rd_en cycle 1, last wr_en cycle 52, done cycle 53.

Optional Feature:
- Macro NTT_CTRL_HOLD_EN.
- Defined: adds input port hold (1 bit).
  - hold=1 in RUN suppresses issue (rd_en=0) and freezes k and state.
  - The delay line keeps advancing, with a 0 tag for held cycles.
  - hold is ignored in IDLE, DRAIN and DONE.
  - Stage period grows by the number of held RUN cycles.
- Undefined: port absent; issue every RUN cycle.

Test Plan:
- Reset: assert reset -> all outputs 0, state IDLE; start pulse during reset -> nothing issued.
- Defaults (LOGN=4), start in cycle 0:
  - stage 0 pairs (0,8)..(7,15), tw 0..7;
  - stage 1 pairs (0,4),(1,5),(2,6),(3,7),(8,12)..(11,15), tw 0,2,4,6,0,2,4,6;
  - stage 3 pairs (0,1),(2,3)..(14,15), tw all 0.
- Timing with a model butterfly (valid = en delayed 4 cycles):
  - wr_en mirrors rd_en 5 cycles later, same addresses;
  - no rd_en in the cycle of or before any stage's last write;
  - done at cycle 53; busy high cycles 1..53; align_err stays 0.
- Control: start held high through a whole run, and pulsed in DONE -> exactly one transform, one done pulse.
- Misalignment and reset: model butterfly latency 3 -> align_err=1 and stays 1; reset at cycle 20 -> immediate IDLE, no wr_en, no done.
- With NTT_CTRL_HOLD_EN: hold high for 3 cycles at k=2 in stage 0 -> k sequence repeats 2, no duplicate pairs, done at cycle 56.
